exc_pc_sequencer: RTL and testbench

Multi-cycle exception/return sequencer that drives the PC-source select and PC write enable of the next-PC path. It holds the EPC register and fetches the exception handler address from the memory vector table. It also performs the return-from-exception reload of PC from EPC. It sits beside the main control FSM: it takes PC control while `busy` is high and releases it after a one-cycle `done` pulse.

---
 rtl/exc_pc_sequencer.sv | 129 ++++++++++++
 tb/tb_exc_pc_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_pc_sequencer.sv
// rtl/exc_pc_sequencer.sv - exception/return PC sequencer with EPC and vector fetch
//
// Takes over the next-PC path while busy: saves EPC, reads the handler byte
// from the vector table and loads it into PC, or reloads PC from EPC on rte.
// Ports:
//   clk, reset                       clock, async active-high reset
//   exc_opcode/exc_overflow/exc_div0 exception requests (sampled in IDLE)
//   rte                              return-from-exception request (IDLE only)
//   pc_in                            current PC + 4
//   pc_src, pc_write                 next-PC select and PC load enable
//   mem_read, mem_addr               vector-table read request and address
//   epc, cause                       saved PC and last cause
//   busy, done                       sequencer owns PC control / completion pulse
module exc_pc_sequencer #(
  parameter int unsigned MEM_LAT  = 2,
  parameter logic [31:0] VEC_BASE = 32'd253
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic        rte,
  input  logic [31:0] pc_in,
  output logic [1:0]  pc_src,
  output logic        pc_write,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_FETCH,
    S_LOAD,
    S_RET,
    S_DONE
  } state_t;

  localparam logic [3:0] FETCH_LAST = 4'(MEM_LAT - 1);

  state_t      state;
  logic [3:0]  fetch_cnt;
  logic [31:0] vec_addr;
  logic        any_exc;

  // cause is 1..3 whenever this is used, so cause-1 selects the table slot
  assign vec_addr = VEC_BASE + {30'd0, cause} - 32'd1;
  assign any_exc  = exc_opcode | exc_overflow | exc_div0;

  // Outputs are registered alongside the state so each one reflects the
  // state being entered; they therefore decode purely from state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      fetch_cnt <= 4'd0;
      epc       <= 32'd0;
      cause     <= 2'b00;
      pc_src    <= 2'b00;
      pc_write  <= 1'b0;
      mem_read  <= 1'b0;
      mem_addr  <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_exc) begin
            state <= S_SAVE;
            busy  <= 1'b1;
            if (exc_opcode)        cause <= 2'b01;
            else if (exc_overflow) cause <= 2'b10;
            else                   cause <= 2'b11;
          end else if (rte) begin
            state    <= S_RET;
            busy     <= 1'b1;
            pc_write <= 1'b1;
            pc_src   <= 2'b01;
          end
        end
        S_SAVE: begin
          epc       <= pc_in - 32'd4;
          state     <= S_FETCH;
          fetch_cnt <= 4'd0;
          mem_read  <= 1'b1;
          mem_addr  <= vec_addr;
        end
        S_FETCH: begin
          if (fetch_cnt == FETCH_LAST) begin
            state     <= S_LOAD;
            fetch_cnt <= 4'd0;
            mem_read  <= 1'b0;
            mem_addr  <= 32'd0;
            pc_write  <= 1'b1;
            pc_src    <= 2'b11;
          end else begin
            fetch_cnt <= fetch_cnt + 4'd1;
          end
        end
        S_LOAD, S_RET: begin
          state    <= S_DONE;
          pc_write <= 1'b0;
          pc_src   <= 2'b00;
          done     <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          fetch_cnt <= 4'd0;
          pc_src    <= 2'b00;
          pc_write  <= 1'b0;
          mem_read  <= 1'b0;
          mem_addr  <= 32'd0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_pc_sequencer.sv
// tb/tb_exc_pc_sequencer.sv - self-checking bench for exc_pc_sequencer
module tb_exc_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exc_opcode = 1'b0;
  logic        exc_overflow = 1'b0;
  logic        exc_div0 = 1'b0;
  logic        rte = 1'b0;
  logic [31:0] pc_in = 32'd0;

  logic [1:0]  pc_src_w   [3];
  logic        pc_write_w [3];
  logic        mem_read_w [3];
  logic [31:0] mem_addr_w [3];
  logic [31:0] epc_w      [3];
  logic [1:0]  cause_w    [3];
  logic        busy_w     [3];
  logic        done_w     [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 15;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 2 : 15;
    exc_pc_sequencer #(.MEM_LAT(L), .VEC_BASE(32'd253)) dut (
      .clk          (clk),
      .reset        (reset),
      .exc_opcode   (exc_opcode),
      .exc_overflow (exc_overflow),
      .exc_div0     (exc_div0),
      .rte          (rte),
      .pc_in        (pc_in),
      .pc_src       (pc_src_w[g]),
      .pc_write     (pc_write_w[g]),
      .mem_read     (mem_read_w[g]),
      .mem_addr     (mem_addr_w[g]),
      .epc          (epc_w[g]),
      .cause        (cause_w[g]),
      .busy         (busy_w[g]),
      .done         (done_w[g])
    );
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (MEM_LAT=%0d) t=%0t got=%h want=%h", nm, lat_of(i), $time, act, exp);
    end
  endtask

  // Model: a sequence is a cycle index t (0 = idle). An exception sequence
  // lasts MEM_LAT+3 cycles, a return lasts 2; every output follows from t.
  int          mt    [3];
  int          mkind [3];   // 0 = exception, 1 = return
  logic [1:0]  mcause[3];
  logic [31:0] mepc  [3];
  int          busy_cnt[3];
  int          rd_cnt  [3];

  function automatic int total_of(input int i, input int kind);
    return (kind == 0) ? lat_of(i) + 3 : 2;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        mt[i]     <= 0;
        mkind[i]  <= 0;
        mcause[i] <= 2'd0;
        mepc[i]   <= 32'd0;
      end else if (mt[i] == 0) begin
        if (exc_opcode || exc_overflow || exc_div0) begin
          mkind[i]  <= 0;
          mt[i]     <= 1;
          mcause[i] <= exc_opcode ? 2'd1 : exc_overflow ? 2'd2 : 2'd3;
        end else if (rte) begin
          mkind[i] <= 1;
          mt[i]    <= 1;
        end
      end else begin
        if (mkind[i] == 0 && mt[i] == 1) mepc[i] <= pc_in - 32'd4;
        mt[i] <= (mt[i] == total_of(i, mkind[i])) ? 0 : mt[i] + 1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      busy_cnt[i] = 0;
      rd_cnt[i]   = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int   t;
      int   lat;
      logic exc;
      logic e_pw;
      logic e_rd;
      t   = mt[i];
      lat = lat_of(i);
      exc = (mkind[i] == 0);
      e_pw = (t != 0) && (exc ? (t == lat + 2) : (t == 1));
      e_rd = (t != 0) && exc && (t >= 2) && (t <= lat + 1);
      chk("busy", i, 32'(busy_w[i]), 32'(t != 0));
      chk("done", i, 32'(done_w[i]), 32'((t != 0) && (t == total_of(i, mkind[i]))));
      chk("pc_write", i, 32'(pc_write_w[i]), 32'(e_pw));
      chk("pc_src", i, 32'(pc_src_w[i]), e_pw ? (exc ? 32'd3 : 32'd1) : 32'd0);
      chk("mem_read", i, 32'(mem_read_w[i]), 32'(e_rd));
      chk("mem_addr", i, mem_addr_w[i], e_rd ? 32'd252 + 32'(mcause[i]) : 32'd0);
      chk("epc", i, epc_w[i], mepc[i]);
      chk("cause", i, 32'(cause_w[i]), 32'(mcause[i]));
      busy_cnt[i] = busy_cnt[i] + 32'(busy_w[i]);
      rd_cnt[i]   = rd_cnt[i] + 32'(mem_read_w[i]);
    end
  end

  // Drive one request at a negedge; returns at the negedge of cycle 1.
  task automatic req(input logic o, input logic ov, input logic d, input logic r, input logic [31:0] pc);
    @(negedge clk);
    exc_opcode = o; exc_overflow = ov; exc_div0 = d; rte = r; pc_in = pc;
    @(negedge clk);
    exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0; rte = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int b0, b2, r1, r2;
    reset = 1'b1;
    wait_cyc(2);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", i, 32'(busy_w[i]), 32'd0);
      chk("rst_epc", i, epc_w[i], 32'd0);
    end
    reset = 1'b0;
    wait_cyc(2);

    // opcode exception, default latency, cycle-by-cycle literals
    req(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040);
    chk("op_c1_cause", 1, 32'(cause_w[1]), 32'd1);
    chk("op_c1_pw", 1, 32'(pc_write_w[1]), 32'd0);
    wait_cyc(1);
    chk("op_c2_epc", 1, epc_w[1], 32'h3C);
    chk("op_c2_addr", 1, mem_addr_w[1], 32'd253);
    wait_cyc(1);
    chk("op_c3_addr", 1, mem_addr_w[1], 32'd253);
    wait_cyc(1);
    chk("op_c4_pw", 1, 32'(pc_write_w[1]), 32'd1);
    chk("op_c4_src", 1, 32'(pc_src_w[1]), 32'd3);
    wait_cyc(1);
    chk("op_c5_done", 1, 32'(done_w[1]), 32'd1);
    wait_cyc(1);
    chk("op_c6_busy", 1, 32'(busy_w[1]), 32'd0);
    wait_cyc(16);

    // overflow and div0 together: overflow wins
    req(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0100);
    chk("ov_cause", 1, 32'(cause_w[1]), 32'd2);
    wait_cyc(1);
    chk("ov_addr", 1, mem_addr_w[1], 32'd254);
    chk("ov_epc", 1, epc_w[1], 32'hFC);
    wait_cyc(20);

    // div0 alone
    req(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100);
    wait_cyc(1);
    chk("dz_addr", 1, mem_addr_w[1], 32'd255);
    wait_cyc(20);

    // pc_in = 0 wraps; sequence lengths at MEM_LAT 1 and 15
    b0 = busy_cnt[0]; b2 = busy_cnt[2]; r1 = rd_cnt[1]; r2 = rd_cnt[2];
    req(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000);
    wait_cyc(1);
    chk("wrap_epc", 1, epc_w[1], 32'hFFFF_FFFC);
    wait_cyc(21);
    chk("lat1_busy_len", 0, 32'(busy_cnt[0] - b0), 32'd4);
    chk("lat15_busy_len", 2, 32'(busy_cnt[2] - b2), 32'd18);
    chk("lat15_fetch_len", 2, 32'(rd_cnt[2] - r2), 32'd15);
    chk("lat2_fetch_len", 1, 32'(rd_cnt[1] - r1), 32'd2);

    // exception, then rte held through busy and beyond
    req(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200);
    rte = 1'b1;
    wait_cyc(5);
    chk("rte_c6_idle", 1, 32'(busy_w[1]), 32'd0);
    wait_cyc(1);
    chk("rte_c7_pw", 1, 32'(pc_write_w[1]), 32'd1);
    chk("rte_c7_src", 1, 32'(pc_src_w[1]), 32'd1);
    chk("rte_c7_epc", 1, epc_w[1], 32'h1FC);
    wait_cyc(1);
    chk("rte_c8_pw", 1, 32'(pc_write_w[1]), 32'd0);
    chk("rte_c8_done", 1, 32'(done_w[1]), 32'd1);
    wait_cyc(14);
    rte = 1'b0;
    wait_cyc(6);

    // rte and opcode together: exception path, no RET
    req(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
    chk("both_c1_pw", 1, 32'(pc_write_w[1]), 32'd0);
    wait_cyc(1);
    chk("both_c2_rd", 1, 32'(mem_read_w[1]), 32'd1);
    chk("both_c2_epc", 1, epc_w[1], 32'h2FC);
    wait_cyc(20);

    // asynchronous reset in FETCH
    req(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0080);
    wait_cyc(1);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("arst_busy", i, 32'(busy_w[i]), 32'd0);
      chk("arst_rd", i, 32'(mem_read_w[i]), 32'd0);
      chk("arst_addr", i, mem_addr_w[i], 32'd0);
      chk("arst_pw", i, 32'(pc_write_w[i]), 32'd0);
      chk("arst_src", i, 32'(pc_src_w[i]), 32'd0);
      chk("arst_done", i, 32'(done_w[i]), 32'd0);
      chk("arst_epc", i, epc_w[i], 32'd0);
      chk("arst_cause", i, 32'(cause_w[i]), 32'd0);
    end
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(1);
    req(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0080);
    wait_cyc(1);
    chk("post_rst_epc", 1, epc_w[1], 32'h7C);
    wait_cyc(2);
    chk("post_rst_pw", 1, 32'(pc_write_w[1]), 32'd1);
    wait_cyc(1);
    chk("post_rst_done", 1, 32'(done_w[1]), 32'd1);
    wait_cyc(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
